// File: rtl/sequence_generator.sv
// Serial bit-stream source: shifts a latched pattern out MSB-first on w,
// optionally repeating it with a fixed idle gap between repetitions.
module sequence_generator #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] pattern_reg, pattern_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] rep_reg, rep_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             w_reg, w_next;
    logic             w_valid_reg, w_valid_next;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] bit_hits;

    assign len_eff = (len > WIDTH_L) ? WIDTH_L : len;

    always_comb begin
        state_next   = state_reg;
        pattern_next = pattern_reg;
        len_next     = len_reg;
        idx_next     = idx_reg;
        rep_next     = rep_reg;
        gap_next     = gap_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    pattern_next = pattern;
                    len_next     = len_eff;
                    rep_next     = rep;
                    if (len_eff != '0) begin
                        state_next = S_SEND;
                        idx_next   = len_eff - LEN_W'(1);
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (idx_reg != '0) begin
                    idx_next = idx_reg - LEN_W'(1);
                end else if (rep_reg != '0) begin
                    // Last bit of a repetition with more to follow.
                    if (GAP > 0) begin
                        state_next = S_GAP;
                        gap_next   = GAP_LOAD;
                    end else begin
                        idx_next = len_reg - LEN_W'(1);
                        rep_next = rep_reg - CNT_W'(1);
                    end
                end else begin
                    state_next = S_DONE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (gap_reg != '0) begin
                    gap_next = gap_reg - GAP_W'(1);
                end else begin
                    state_next = S_SEND;
                    idx_next   = len_reg - LEN_W'(1);
                    if (rep_reg != '0) begin
                        rep_next = rep_reg - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Bit select of the next pattern bit without a narrowing index.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
            assign bit_hits[gi] = (idx_next == LEN_W'(gi)) & pattern_next[gi];
        end
    endgenerate

    assign w_valid_next = (state_next == S_SEND);
    assign w_next       = w_valid_next & (|bit_hits);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            pattern_reg <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            rep_reg     <= '0;
            gap_reg     <= '0;
            w_reg       <= 1'b0;
            w_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
            len_reg     <= len_next;
            idx_reg     <= idx_next;
            rep_reg     <= rep_next;
            gap_reg     <= gap_next;
            w_reg       <= w_next;
            w_valid_reg <= w_valid_next;
        end
    end

    assign ready   = (state_reg == S_IDLE);
    assign done    = (state_reg == S_DONE);
    assign w       = w_reg;
    assign w_valid = w_valid_reg;

endmodule
